// File: rtl/lfsr_pkg.sv
// Shared LFSR helpers: Galois step functions and polynomial constants.
// Functions work on 32-bit containers; callers pass W-bit zero-extended values.
package lfsr_pkg;

  localparam int MAXW = 32;

  localparam logic [3:0]  POLY4  = 4'hC;
  localparam logic [7:0]  POLY8  = 8'hB8;
  localparam logic [15:0] POLY16 = 16'hB400;
  localparam logic [31:0] POLY32 = 32'h8020_0003;
  localparam logic [15:0] SEED16 = 16'hACE1;

  function automatic logic [31:0] galois_step(
    input logic [31:0] s,
    input logic [31:0] taps
  );
    return (s >> 1) ^ ({32{s[0]}} & taps);
  endfunction

  function automatic logic [31:0] galois_steps(
    input logic [31:0] s,
    input logic [31:0] taps,
    input int          n
  );
    logic [31:0] r;
    r = s;
    for (int i = 0; i < MAXW; i++) begin
      if (i < n) r = galois_step(r, taps);
    end
    return r;
  endfunction

endpackage

// File: rtl/lfsr_if.sv
// LFSR control/status bundle.
// master drives en/load/load_val; slave returns Q, lockup, wrap, period.
interface lfsr_if #(
  parameter int W  = 16,
  parameter int PW = 17
);
  logic          en;
  logic          load;
  logic [W-1:0]  load_val;
  logic [W-1:0]  Q;
  logic          lockup;
  logic          wrap;
  logic [PW-1:0] period;

  modport master (
    output en, load, load_val,
    input  Q, lockup, wrap, period
  );

  modport slave (
    input  en, load, load_val,
    output Q, lockup, wrap, period
  );
endinterface

// File: rtl/lfsr_period_mon.sv
// Period monitor: tracks reference state, enabled-cycle count and wrap.
// Ports: restart/restart_val rebase ref; adv/nxt advance; wrap, period out.
module lfsr_period_mon #(
  parameter int           W      = 16,
  parameter int           PW     = 17,
  parameter logic [W-1:0] SEED_W = '1
) (
  input  logic          CLK,
  input  logic          n_RESET,
  input  logic          restart,
  input  logic [W-1:0]  restart_val,
  input  logic          adv,
  input  logic [W-1:0]  nxt,
  output logic          wrap,
  output logic [PW-1:0] period
);

  localparam logic [PW-1:0] CMAX = '1;

  logic [W-1:0]  ref_q, ref_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] per_q, per_d;
  logic          wrap_q, wrap_d;
  logic [PW-1:0] cnt_inc;

  always_comb begin
    cnt_inc = (cnt_q == CMAX) ? CMAX : cnt_q + PW'(1);
    ref_d   = ref_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    wrap_d  = 1'b0;
    if (restart) begin
      ref_d = restart_val;
      cnt_d = '0;
    end else if (adv) begin
      if (nxt == ref_q) begin
        wrap_d = 1'b1;
        per_d  = cnt_inc;
        cnt_d  = '0;
      end else begin
        cnt_d  = cnt_inc;
      end
    end
  end

  always_ff @(posedge CLK or negedge n_RESET) begin
    if (!n_RESET) begin
      ref_q  <= SEED_W;
      cnt_q  <= '0;
      per_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      ref_q  <= ref_d;
      cnt_q  <= cnt_d;
      per_q  <= per_d;
      wrap_q <= wrap_d;
    end
  end

  assign wrap   = wrap_q;
  assign period = per_q;

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised Galois LFSR with load, zero lock-up recovery, period monitor.
// Ports: CLK, n_RESET (async low), bus (lfsr_if.slave).
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int          W     = 16,
  parameter logic [31:0] TAPS  = 32'(POLY16),
  parameter logic [31:0] SEED  = 32'(SEED16),
  parameter int          STEPS = 1,
  parameter int          PW    = 17
) (
  input  logic CLK,
  input  logic n_RESET,
  lfsr_if.slave bus
);

  localparam logic [W-1:0] TAPS_W = TAPS[W-1:0];
  localparam logic [W-1:0] SEED_W = SEED[W-1:0];

  if (W < 4 || W > 32) begin : g_bad_w
    $error("lfsr_gen: W out of range");
  end
  if (TAPS_W[W-1] != 1'b1) begin : g_bad_taps
    $error("lfsr_gen: TAPS[W-1] must be 1");
  end
  if (SEED_W == '0) begin : g_bad_seed
    $error("lfsr_gen: SEED must be non-zero");
  end
  if (STEPS < 1 || STEPS > W) begin : g_bad_steps
    $error("lfsr_gen: STEPS out of range");
  end

  logic [W-1:0] q_q, q_d;
  logic         lock_q, lock_d;
  logic [W-1:0] step_w;
  logic         restart;
  logic [W-1:0] restart_val;
  logic         adv;

  assign step_w = W'(galois_steps(32'(q_q), 32'(TAPS_W), STEPS));

  // load beats lock-up recovery beats a normal shift
  always_comb begin
    q_d         = q_q;
    lock_d      = 1'b0;
    restart     = 1'b0;
    restart_val = SEED_W;
    adv         = 1'b0;
    if (bus.load) begin
      q_d         = bus.load_val;
      restart     = 1'b1;
      restart_val = bus.load_val;
    end else if (bus.en && q_q == '0) begin
      q_d     = SEED_W;
      lock_d  = 1'b1;
      restart = 1'b1;
    end else if (bus.en) begin
      q_d = step_w;
      adv = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge n_RESET) begin
    if (!n_RESET) begin
      q_q    <= SEED_W;
      lock_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      lock_q <= lock_d;
    end
  end

  lfsr_period_mon #(
    .W      (W),
    .PW     (PW),
    .SEED_W (SEED_W)
  ) u_mon (
    .CLK         (CLK),
    .n_RESET     (n_RESET),
    .restart     (restart),
    .restart_val (restart_val),
    .adv         (adv),
    .nxt         (step_w),
    .wrap        (bus.wrap),
    .period      (bus.period)
  );

  assign bus.Q      = q_q;
  assign bus.lockup = lock_q;

endmodule

// File: doc/lfsr_gen.md
Name: lfsr_gen

Overview:
Parametrised Galois LFSR pseudo-random generator. Successor to the fixed 16-bit seeded shift register.
- Adds configurable width, polynomial and seed.
- Adds multiple shift steps per clock, run-time enable and seed load.
- Adds zero-state lock-up recovery and on-line period measurement.
- Feeds test-pattern, scrambler and noise sources in the lab designs.

Parameters:
W, 16, LFSR width in bits (4..32)
TAPS, 16'hB400, Galois tap mask; bit i set => Q[0] XORed into next[i]; TAPS[W-1] must be 1
SEED, 16'hACE1, reset value and lock-up recovery value; must be non-zero
STEPS, 1, LFSR shifts applied per enabled clock (1..W)
PW, 17, period counter width

Ports:
CLK  input  1  clock
n_RESET  input  1  asynchronous, active-low reset; clock CLK
en  input  1  advance STEPS shifts this cycle
load  input  1  load load_val this cycle (priority over en)
load_val  input  W  value for load
Q  output  W  current LFSR state
lockup  output  1  one-cycle pulse: zero state detected and replaced by SEED
wrap  output  1  one-cycle pulse: state returned to reference value
period  output  PW  enabled-cycle count of last completed period, saturating

Behaviour:
- Single step function: next = (Q >> 1) ^ ({W{Q[0]}} & TAPS). One enabled cycle applies it STEPS times combinationally.
- Reset (async, n_RESET=0):
  - Q=SEED, ref=SEED, cnt=0, period=0, lockup=0, wrap=0.
- Priority each rising CLK: load > lockup recovery > en > hold.
- load=1:
  - Q<=load_val, ref<=load_val, cnt<=0; lockup/wrap <= 0.
  - period unchanged; en is ignored.
  - Loading 0 is legal; it is repaired on the next enabled cycle.
- Lock-up recovery, when en=1 and Q==0:
  - Q<=SEED, ref<=SEED, cnt<=0, lockup<=1.
  - No shift this cycle; wrap<=0.
- en=1, Q!=0:
  - Q<=step^STEPS(Q); cnt<=cnt+1, saturating at 2^PW-1.
  - If step^STEPS(Q)==ref: wrap<=1, period<=cnt+1 (saturated), cnt<=0.
  - Comparison is on the post-cycle state only. Returns to ref inside a STEPS group are not detected; period is measured in enabled cycles.
- en=0, load=0:
  - All state holds; lockup and wrap <= 0.
- Latency: Q reflects en/load one cycle after the sampling edge. lockup and wrap are registered and assert in the same cycle as the new Q.
- Non-zero Q never reaches 0 by stepping when TAPS[W-1]=1; the zero check only covers loads.
- Reset asserted mid-period discards cnt. period returns to 0.
- Elaboration errors:
  - TAPS[W-1]==0, SEED==0, STEPS==0 or STEPS>W.
  - SEED or TAPS wider than W: truncated to W bits, and the check is made on the truncated value.

Decomposition:
- Package lfsr_pkg holds:
  - function galois_step(state, taps) and a multi-step wrapper.
  - Maximal-polynomial constants: POLY4=4'hC, POLY8=8'hB8, POLY16=16'hB400, POLY32=32'h8020_0003.
  - Default seed constant SEED16=16'hACE1.
- Natural sub-module: lfsr_period_mon, containing ref, cnt, the wrap compare, period and saturation.
- lfsr_gen keeps the state register, load/lock-up priority and step logic.

Test Plan:
- Reset, then en=1 for 3 cycles, defaults -> Q: ACE1, E270, 7138, 389C; lockup=0, wrap=0 throughout.
- W=4, TAPS=4'hC, SEED=4'h1, en held high -> Q sequence C,6,3,D,A,5,E,7,F,B,9,8,4,2,1; wrap pulses on the 15th edge; period=15; pattern repeats.
- Defaults with STEPS=2 -> first enabled edge Q=7138; after 65535 single-step cycles with STEPS=1, wrap=1 and period=65535.
- Lock-up: load=1, load_val=0 -> Q=0; next edge with en=1 -> Q=ACE1, lockup=1 for exactly one cycle. The following edge -> Q=E270, lockup=0.
- Load vs en priority: load=1, en=1, load_val=16'h1234 -> Q=1234 and cnt cleared. The next en edge -> Q=091A.
- en gaps and async reset: toggle en 0/1 mid-period -> Q holds on en=0 and period counts enabled cycles only. Assert n_RESET between edges -> Q=ACE1 immediately, period=0.
